// File: rtl/mem_store_buffer_pkg.sv
// Shared bus widths, store-size encodings and the buffer entry layout.
package mem_store_buffer_pkg;

  localparam int DATA_BUS    = 32;
  localparam int ADDR_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } store_size_e;

  typedef struct packed {
    logic [ADDR_BUS-1:0]    addr;
    logic [MEM_SEL_BUS-1:0] sel;
    logic [DATA_BUS-1:0]    data;
  } sb_entry_t;

  // Word-aligned base of a byte address.
  function automatic logic [ADDR_BUS-1:0] word_base(input logic [ADDR_BUS-1:0] a);
    return {a[ADDR_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_store_buffer_if.sv
// Store, load-probe and RAM write signals of the store buffer.
// slave is the buffer's view; master is the MEM stage / RAM side.
interface mem_store_buffer_if;
  import mem_store_buffer_pkg::*;

  logic                   store_req;
  logic [1:0]             store_size;
  logic [ADDR_BUS-1:0]    store_addr;
  logic [DATA_BUS-1:0]    store_data;
  logic                   store_ready;
  logic                   store_misaligned;
  logic [ADDR_BUS-1:0]    load_addr;
  logic                   load_hit;
  logic                   ram_en;
  logic [MEM_SEL_BUS-1:0] ram_write_sel;
  logic [ADDR_BUS-1:0]    ram_addr;
  logic [DATA_BUS-1:0]    ram_write_data;
  logic                   ram_ack;

  modport slave (
    input  store_req, store_size, store_addr, store_data, load_addr, ram_ack,
    output store_ready, store_misaligned, load_hit,
           ram_en, ram_write_sel, ram_addr, ram_write_data
  );

  modport master (
    output store_req, store_size, store_addr, store_data, load_addr, ram_ack,
    input  store_ready, store_misaligned, load_hit,
           ram_en, ram_write_sel, ram_addr, ram_write_data
  );

endinterface

// File: rtl/mem_store_buffer_store_align.sv
// Combinational store encoder: size and byte offset to lane enables,
// lane-replicated data and a misalignment flag.
module store_align
  import mem_store_buffer_pkg::*;
(
  input  logic                   req_i,
  input  logic [1:0]             size_i,
  input  logic [1:0]             addr_lo_i,
  input  logic [DATA_BUS-1:0]    data_i,
  output logic [MEM_SEL_BUS-1:0] sel_o,
  output logic [DATA_BUS-1:0]    data_o,
  output logic                   misaligned_o
);

  logic bad;

  // Decode size into lane enables and replicated data; illegal size is always bad.
  always_comb begin
    sel_o  = '0;
    data_o = '0;
    bad    = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        sel_o  = 4'b0001 << addr_lo_i;
        data_o = {4{data_i[7:0]}};
      end
      SZ_HALF: begin
        sel_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o = {2{data_i[15:0]}};
        bad    = addr_lo_i[0];
      end
      SZ_WORD: begin
        sel_o  = 4'b1111;
        data_o = data_i;
        bad    = (addr_lo_i != 2'b00);
      end
      default: begin
        bad    = 1'b1;
      end
    endcase
  end

  // Only a live request can be flagged.
  assign misaligned_o = req_i & bad;

endmodule

// File: rtl/mem_store_buffer.sv
// In-order store buffer between the MEM stage and a write-only RAM port.
// Aligned stores are queued and drained head-first; loads probe for a
// word-address hit against any buffered entry.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  mem_store_buffer_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  sb_entry_t              entry_q [DEPTH];

  logic [MEM_SEL_BUS-1:0] enc_sel;
  logic [DATA_BUS-1:0]    enc_data;
  logic                   enc_mis;
  logic                   ready;
  logic                   nonempty;
  logic                   push;
  logic                   pop;
  logic                   hit;
  logic                   unused_load_lo;

  store_align u_align (
    .req_i       (bus.store_req),
    .size_i      (bus.store_size),
    .addr_lo_i   (bus.store_addr[1:0]),
    .data_i      (bus.store_data),
    .sel_o       (enc_sel),
    .data_o      (enc_data),
    .misaligned_o(enc_mis)
  );

  // Readiness ignores a same-cycle pop, so a full buffer never pushes.
  assign ready    = (count_q < DEPTH_C);
  assign nonempty = (count_q != '0);
  assign push     = bus.store_req & ready & ~enc_mis;
  assign pop      = nonempty & bus.ram_ack;

  // Next pointers, valid bits and occupancy from push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (push) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (pop) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every pending entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload; only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[tail_q] <= '{addr: word_base(bus.store_addr), sel: enc_sel, data: enc_data};
    end
  end

  // Load probe against committed entries only; the one being pushed is not yet visible.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].addr[ADDR_BUS-1:2] == bus.load_addr[ADDR_BUS-1:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign unused_load_lo = ^bus.load_addr[1:0];

  assign bus.store_ready      = ready;
  assign bus.store_misaligned = enc_mis;
  assign bus.load_hit         = hit;
  assign bus.ram_en           = nonempty;
  assign bus.ram_addr         = nonempty ? entry_q[head_q].addr : '0;
  assign bus.ram_write_sel    = nonempty ? entry_q[head_q].sel  : '0;
  assign bus.ram_write_data   = nonempty ? entry_q[head_q].data : '0;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: vector table plus reset sequences.
module tb_mem_store_buffer;

  logic clk;
  logic rst;

  mem_store_buffer_if sb_if();

  mem_store_buffer #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ack;
    logic [31:0] laddr;
    logic        e_rdy;
    logic        e_mis;
    logic        e_en;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_hit;
  } vec_t;

  vec_t vt[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic req, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] data, input logic ack, input logic [31:0] laddr,
                     input logic rdy, input logic mis, input logic en, input logic [3:0] sel,
                     input logic [31:0] raddr, input logic [31:0] wdata, input logic hit);
    vec_t v;
    v.req = req; v.size = size; v.addr = addr; v.data = data; v.ack = ack; v.laddr = laddr;
    v.e_rdy = rdy; v.e_mis = mis; v.e_en = en; v.e_sel = sel;
    v.e_addr = raddr; v.e_wdata = wdata; v.e_hit = hit;
    vt.push_back(v);
  endtask

  task automatic drive(input logic req, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data, input logic ack, input logic [31:0] laddr);
    sb_if.store_req  = req;
    sb_if.store_size = size;
    sb_if.store_addr = addr;
    sb_if.store_data = data;
    sb_if.ram_ack    = ack;
    sb_if.load_addr  = laddr;
  endtask

  task automatic check(input string name, input logic rdy, input logic mis, input logic en,
                       input logic [3:0] sel, input logic [31:0] raddr,
                       input logic [31:0] wdata, input logic hit);
    n_vec++;
    if (sb_if.store_ready !== rdy || sb_if.store_misaligned !== mis || sb_if.ram_en !== en ||
        sb_if.ram_write_sel !== sel || sb_if.ram_addr !== raddr ||
        sb_if.ram_write_data !== wdata || sb_if.load_hit !== hit) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b mis=%b en=%b sel=%b addr=%h data=%h hit=%b, want rdy=%b mis=%b en=%b sel=%b addr=%h data=%h hit=%b",
               name, sb_if.store_ready, sb_if.store_misaligned, sb_if.ram_en,
               sb_if.ram_write_sel, sb_if.ram_addr, sb_if.ram_write_data, sb_if.load_hit,
               rdy, mis, en, sel, raddr, wdata, hit);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("reset_state", 1, 0, 0, 4'b0000, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    //  req size   addr          data          ack laddr         rdy mis en sel      raddr         wdata         hit
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b00, 32'h1003,     32'h000000AB, 1, 32'h1000,     1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h1000,     1,  0,  1, 4'b1000, 32'h1000,     32'hABABABAB, 1);
    add(1, 2'b01, 32'h2002,     32'h00001234, 0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b01, 32'h2001,     32'h00005678, 0, 32'h0,        1,  1,  1, 4'b1100, 32'h2000,     32'h12341234, 0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        1,  0,  1, 4'b1100, 32'h2000,     32'h12341234, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b10, 32'h3002,     32'h12345678, 0, 32'h0,        1,  1,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b11, 32'h3000,     32'h12345678, 0, 32'h0,        1,  1,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(0, 2'b11, 32'h3001,     32'h0,        0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b10, 32'h4000,     32'h11111111, 0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b10, 32'h4004,     32'h22222222, 0, 32'h0,        1,  0,  1, 4'b1111, 32'h4000,     32'h11111111, 0);
    add(1, 2'b10, 32'h4008,     32'h33333333, 0, 32'h0,        1,  0,  1, 4'b1111, 32'h4000,     32'h11111111, 0);
    add(1, 2'b10, 32'h400C,     32'h44444444, 0, 32'h0,        1,  0,  1, 4'b1111, 32'h4000,     32'h11111111, 0);
    add(1, 2'b10, 32'h4010,     32'h55555555, 0, 32'h0,        0,  0,  1, 4'b1111, 32'h4000,     32'h11111111, 0);
    add(1, 2'b10, 32'h4010,     32'h55555555, 1, 32'h0,        0,  0,  1, 4'b1111, 32'h4000,     32'h11111111, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h400C,     1,  0,  1, 4'b1111, 32'h4004,     32'h22222222, 1);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h4010,     1,  0,  1, 4'b1111, 32'h4004,     32'h22222222, 0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        1,  0,  1, 4'b1111, 32'h4008,     32'h33333333, 0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        1,  0,  1, 4'b1111, 32'h400C,     32'h44444444, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b10, 32'h3000,     32'hCAFEF00D, 1, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h3002,     1,  0,  1, 4'b1111, 32'h3000,     32'hCAFEF00D, 1);
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h3004,     1,  0,  1, 4'b1111, 32'h3000,     32'hCAFEF00D, 0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h3000,     1,  0,  1, 4'b1111, 32'h3000,     32'hCAFEF00D, 1);
    add(1, 2'b00, 32'h5000,     32'hFFFFFFCD, 0, 32'h3000,     1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(1, 2'b01, 32'h6004,     32'hAAAA9876, 1, 32'h0,        1,  0,  1, 4'b0001, 32'h5000,     32'hCDCDCDCD, 0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h6006,     1,  0,  1, 4'b0011, 32'h6004,     32'h98769876, 1);
    add(1, 2'b00, 32'h7001,     32'h0000005A, 0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        1,  0,  1, 4'b0010, 32'h7000,     32'h5A5A5A5A, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0, 4'b0000, 32'h0,        32'h0,        0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].size, vt[i].addr, vt[i].data, vt[i].ack, vt[i].laddr);
      #1;
      check($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_mis, vt[i].e_en, vt[i].e_sel,
            vt[i].e_addr, vt[i].e_wdata, vt[i].e_hit);
    end

    // Three pending entries, then an asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 2'b10, 32'h8000 + 32'(4 * k), 32'hD0D0_0000 + 32'(k), 1'b0, 32'h8000);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h8008);
    #1;
    check("pre_rst_pending", 1, 0, 1, 4'b1111, 32'h8000, 32'hD0D00000, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_immediate", 1, 0, 0, 4'b0000, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h8004);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("post_rst%0d", k), 1, 0, 0, 4'b0000, 32'h0, 32'h0, 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entry count (power of 2, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port store_req  input  1  store request from MEM stage, valid this cycle.
REQ-005 SHALL have port store_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 SHALL have port store_addr  input  32  byte address of store.
REQ-007 SHALL have port store_data  input  32  unaligned store value; byte in [7:0], halfword in [15:0].
REQ-008 SHALL have port store_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port store_misaligned  output  1  current request is misaligned or illegal.
REQ-010 SHALL have port load_addr  input  32  byte address of load in MEM stage.
REQ-011 SHALL have port load_hit  output  1  a buffered store targets load_addr's word.
REQ-012 SHALL have port ram_en  output  1  RAM write request valid.
REQ-013 SHALL have port ram_write_sel  output  4  byte-lane write enables (MEM_SEL_BUS width).
REQ-014 SHALL have port ram_addr  output  32  word-aligned RAM address, bits [1:0] = 00.
REQ-015 SHALL have port ram_write_data  output  32  lane-aligned write data.
REQ-016 SHALL have port ram_ack  input  1  RAM accepted the current write this cycle.

Function
REQ-017 SHALL flag store_misaligned combinationally when store_req=1 and (size=01 with addr[0]=1, or size=10 with addr[1:0]!=00, or size=11); otherwise 0.
REQ-018 SHALL push one entry when store_req=1, store_ready=1, store_misaligned=0; misaligned requests are dropped.
REQ-019 SHALL encode byte: sel = 0001 << addr[1:0], data = byte replicated to all 4 lanes.
REQ-020 SHALL encode halfword: sel = 0011 (addr[1]=0) or 1100 (addr[1]=1), data = halfword replicated twice.
REQ-021 SHALL encode word: sel = 1111, data = store_data unchanged.
REQ-022 SHALL store per entry: {addr[31:2],2'b00}, sel, data; FIFO order preserved.
REQ-023 SHALL drive store_ready = (count < DEPTH); not pop-aware, so no push when full even if ram_ack pops the same cycle.
REQ-024 SHALL drive ram_en = (count != 0) and ram_addr/ram_write_sel/ram_write_data from the head entry; all 0 when empty.
REQ-025 SHALL pop head on ram_en=1 and ram_ack=1; ram_ack with ram_en=0 is ignored.
REQ-026 SHALL support simultaneous push and pop when not full: count unchanged, both pointers advance.
REQ-027 SHALL make a pushed entry visible on the RAM port one cycle after push (no same-cycle bypass).
REQ-028 SHALL wrap head/tail pointers modulo DEPTH.
REQ-029 SHALL drive load_hit combinationally = OR over valid entries of (entry addr[31:2] == load_addr[31:2]); the entry being pushed this cycle is excluded.
REQ-030 SHALL hold head outputs stable while ram_en=1 and ram_ack=0.

Reset
REQ-031 SHALL on rst=1 asynchronously clear count, head, tail, valid bits; store_ready=1, ram_en=0, ram_write_sel=0, ram_addr=0, ram_write_data=0, load_hit=0.
REQ-032 SHALL discard all buffered entries on reset mid-operation; no partial write completes after reset.

Structure
REQ-033 SHALL take DATA_BUS, ADDR_BUS, MEM_SEL_BUS widths from the shared bus.v include; store_size encodings SHALL be added there as shared constants.
REQ-034 SHALL contain one sub-module, store_align, combinational size/offset -> {sel, data, misaligned} encoder.

Verification
REQ-035 SHALL test sb addr 0x1003 data 0xAB, ram_ack=1 -> one cycle later ram_addr 0x1000, sel 1000, data 0xABABABAB; popped.
REQ-036 SHALL test sh addr 0x2002 data 0x1234 -> sel 1100, data 0x12341234; sh addr 0x2001 -> store_misaligned=1, no entry, ram_en stays 0.
REQ-037 SHALL test 4 sw with ram_ack=0 -> store_ready=0 after 4th; 5th request not taken; then ram_ack=1 -> writes leave in order, count returns to 0.
REQ-038 SHALL test full buffer with store_req and ram_ack same cycle -> pop only, count 3, store_ready=1 next cycle.
REQ-039 SHALL test buffered sw to 0x3000 -> load_addr 0x3002 gives load_hit=1; load_addr 0x3004 gives 0.
REQ-040 SHALL test rst asserted with 3 entries pending -> ram_en=0 immediately, store_ready=1, no further RAM writes.
